mem_data_be: RTL and testbench
==============================

Name: mem_data_be

Overview:
Parametrised data memory for the load/store unit, successor to the single-word data RAM. Byte-addressed, with byte/half/word/dword access sizes, sign or zero extension, and misalignment and range error reporting. Read latency is configurable, and a valid/ready handshake runs on both request and response sides. Sits between the execute/memory stage and the data array; every accepted request returns exactly one response, in order.

Parameters:
WORD, 32, data width in bits; legal values 32 or 64.
ADDR, 16, byte-address width.
DEPTH, 1024, number of WORD-wide entries; DEPTH*WORD/8 <= 2^ADDR.
LAT, 1, request-accept to response-valid latency in cycles, 1..4.
INIT_FILE, "./mem/memfiles/mem_data.dat", hex image; used only with the optional feature.

Ports:
clk  in  1  clock, all logic on posedge.
rst  in  1  synchronous reset, active-high.
req_valid  in  1  request present.
req_ready  out  1  request accepted this cycle when req_valid && req_ready.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  0 byte, 1 half, 2 word, 3 dword.
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
req_addr  in  ADDR  byte address.
req_wdata  in  WORD  store data, right-aligned (low bytes).
resp_valid  out  1  response present.
resp_ready  in  1  consumer accepts the response.
resp_rdata  out  WORD  load result, extended to WORD; 0 for stores and errors.
resp_err  out  1  request was misaligned, out of range or illegal size.

Behaviour:
- NB = WORD/8. Word index = req_addr >> log2(NB). Byte offset = req_addr[log2(NB)-1:0].
- Error conditions:
  - Misaligned: half with addr[0]=1, word with addr[1:0]!=0, dword with addr[2:0]!=0.
  - Illegal size: size 3 with WORD=32.
  - Out of range: word index >= DEPTH.
- Errored request: no array write; response has resp_err=1, resp_rdata=0.
- Pipeline: LAT stages with a valid bit per stage. The whole pipeline advances when the last stage is empty or (resp_valid && resp_ready).
- req_ready = advance. It is combinational from resp_ready and stage valids; no combinational path from req_* to req_ready.
- Store:
  - Commits to the array on the accept edge.
  - Only lanes offset..offset+2^size-1 are written, taken from req_wdata low bytes. Other lanes are unchanged.
- Load:
  - The array is read on the accept edge, so it sees every earlier-accepted store, including one accepted the previous cycle.
  - Selected lanes are shifted to bit 0 and extended per req_unsigned. A full-WORD access ignores req_unsigned.
- Latency: with resp_ready held 1, the response appears exactly LAT cycles after accept; throughput is 1 per cycle.
- Backpressure: when resp_valid && !resp_ready, all stages and outputs hold; req_ready=0 whenever the pipeline is full.
- Idle: resp_rdata and resp_err hold their last value when resp_valid=0.
- Reset (sync): all stage valids=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1 in the first cycle after reset. Array contents are not cleared.
- Reset mid-operation: in-flight responses are dropped without being delivered. A store accepted on the same edge rst is high is not committed.

Optional Feature:
MEM_DATA_BE_FILE_EN.
- Defined: the array is initialised from INIT_FILE with $readmemh at time 0. After every committed store, the whole array is dumped with $writememh to INIT_FILE. Simulation only.
- Undefined: no file I/O; array contents are X until written. The block is synthesisable.

Decomposition:
- Shared package mem_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD, the LAT bounds, and a stage-record typedef {valid, we, err, size, unsigned, offset, rdata_raw}.
- One sub-module, mem_data_align (combinational), covering:
  - store lane-enable and data replication;
  - load lane extraction and sign/zero extension;
  - error decode.

Test Plan:
- LAT=1, WORD=32: store word 0xDEADBEEF @0x10, then load word @0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, one cycle after load accept.
- Load byte @0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE. Load half @0x12 signed -> 0xFFFFDEAD.
- Store byte 0x55 @0x11 over 0xDEADBEEF, then load word @0x10 -> 0xDEAD55EF (other lanes intact).
- Load half @0x11 -> resp_err=1, rdata=0. Store word @DEPTH*4 -> resp_err=1, array unchanged. Size 3 on WORD=32 -> resp_err=1.
- LAT=3, resp_ready=0 for 5 cycles with back-to-back requests -> req_ready falls once 3 stages are full, no response lost or reordered. Release -> 1 response/cycle in issue order.
- Assert rst with 2 loads in flight -> next cycle resp_valid=0, resp_rdata=0, req_ready=1. A following load returns pre-reset stored data.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the byte-enabled data memory.
// Access size codes, latency bounds and the pipeline stage record.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  // Raw read word is sized for the widest legal WORD.
  localparam int RAW_W = 64;

  typedef struct packed {
    logic             valid;
    logic             we;
    logic             err;
    size_e            size;
    logic             uns;
    logic [2:0]       offset;
    logic [RAW_W-1:0] rdata_raw;
  } stage_t;

endpackage

// File: rtl/mem_data_align.sv
// mem_data_align: store lane enables, load extraction/extension,
// and request error decode. Purely combinational.
module mem_data_align
  import mem_pkg::*;
#(
  parameter int WORD  = 32,
  parameter int ADDR  = 16,
  parameter int DEPTH = 1024
) (
  input  logic [1:0]        st_size,
  input  logic [ADDR-1:0]   st_addr,
  input  logic [WORD-1:0]   st_wdata,
  output logic [WORD/8-1:0] st_be,
  output logic [WORD-1:0]   st_data,
  output logic              st_err,
  input  stage_t            ld_stg,
  output logic [WORD-1:0]   ld_rdata
);

  localparam int NB = WORD / 8;
  localparam int OW = $clog2(NB);
  localparam int SW = $clog2(WORD);

  logic [OW-1:0]   st_off;
  logic [ADDR-1:0] st_idx;
  logic            mis;
  logic            ill;
  logic            oor;

  assign st_off = st_addr[OW-1:0];
  assign st_idx = st_addr >> OW;
  assign oor    = 32'(st_idx) >= 32'(DEPTH);
  assign st_err = mis | ill | oor;

  // Alignment and size legality of the incoming request
  always_comb begin
    mis = 1'b0;
    ill = 1'b0;
    unique case (1'b1)
      st_size == SZ_BYTE: mis = 1'b0;
      st_size == SZ_HALF: mis = st_addr[0];
      st_size == SZ_WORD: mis = |st_addr[1:0];
      default: begin
        mis = |st_addr[2:0];
        ill = (WORD == 32);
      end
    endcase
  end

  logic [15:0] be_mask;

  // Byte enables for 2^size lanes, moved up to the byte offset
  always_comb begin
    be_mask = (16'd1 << (5'd1 << st_size)) - 16'd1;
    st_be   = NB'(be_mask << st_off);
    st_data = st_wdata << {st_off, 3'b000};
  end

  logic [WORD-1:0] sh;
  logic [WORD-1:0] mask;
  logic [WORD-1:0] ext;
  logic [OW-1:0]   ld_off;
  logic [SW-1:0]   sbit;
  int              bits;

  // Shift selected lanes to bit 0 and extend; errors/stores read 0
  always_comb begin
    ld_off = ld_stg.offset[OW-1:0];
    sh     = WORD'(ld_stg.rdata_raw) >> {ld_off, 3'b000};
    bits   = 8 << int'(ld_stg.size);
    sbit   = SW'(bits - 1);
    mask   = '1;
    if (bits < WORD) mask = (WORD'(1) << bits) - WORD'(1);
    ext = sh & mask;
    if (!ld_stg.uns && bits < WORD && sh[sbit]) ext = ext | ~mask;
    ld_rdata = (ld_stg.we || ld_stg.err) ? '0 : ext;
  end

  logic unused_ld;
  assign unused_ld = ^{ld_stg.valid, ld_stg.offset, ld_stg.rdata_raw};

endmodule

// File: rtl/mem_data_be.sv
// mem_data_be: byte-addressed data memory, LAT-stage response pipe.
// Byte-lane stores, extended loads, valid/ready on both sides.
module mem_data_be
  import mem_pkg::*;
#(
  parameter int    WORD      = 32,
  parameter int    ADDR      = 16,
  parameter int    DEPTH     = 1024,
  parameter int    LAT       = 1,
  parameter string INIT_FILE = "./mem/memfiles/mem_data.dat"
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [ADDR-1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [WORD-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int NB = WORD / 8;
  localparam int OW = $clog2(NB);
  localparam int IW = $clog2(DEPTH);

  logic [WORD-1:0] mem [DEPTH];

  stage_t          stg [LAT];
  stage_t          s_in;
  logic            adv;
  logic            acc;
  logic            wr_en;
  logic [IW-1:0]   idx;
  logic [NB-1:0]   st_be;
  logic [WORD-1:0] st_data;
  logic            st_err;
  logic [WORD-1:0] ld_rdata;

  assign adv       = !stg[LAT-1].valid || resp_ready;
  assign req_ready = adv;
  assign acc       = req_valid && adv;
  assign wr_en     = acc && req_we && !st_err && !rst;
  assign idx       = IW'(req_addr >> OW);

  mem_data_align #(
    .WORD  (WORD),
    .ADDR  (ADDR),
    .DEPTH (DEPTH)
  ) u_align (
    .st_size  (req_size),
    .st_addr  (req_addr),
    .st_wdata (req_wdata),
    .st_be    (st_be),
    .st_data  (st_data),
    .st_err   (st_err),
    .ld_stg   (stg[LAT-1]),
    .ld_rdata (ld_rdata)
  );

  // Stage-0 record built from the request and the array read
  always_comb begin
    s_in           = '0;
    s_in.valid     = acc;
    s_in.we        = req_we;
    s_in.err       = st_err;
    s_in.size      = size_e'(req_size);
    s_in.uns       = req_unsigned;
    s_in.offset    = 3'(req_addr[OW-1:0]);
    s_in.rdata_raw = (req_we || st_err) ? '0 : RAW_W'(mem[idx]);
  end

  // Byte-lane store commit on the accept edge
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (st_be[b]) mem[idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  // Response pipe; data only moves behind a valid entry so idle holds
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) stg[i] <= '0;
    end else if (adv) begin
      if (s_in.valid) stg[0] <= s_in;
      else stg[0].valid <= 1'b0;
      for (int i = 1; i < LAT; i++) begin
        if (stg[i-1].valid) stg[i] <= stg[i-1];
        else stg[i].valid <= 1'b0;
      end
    end
  end

  assign resp_valid = stg[LAT-1].valid;
  assign resp_err   = stg[LAT-1].err;
  assign resp_rdata = ld_rdata;

  localparam string unused_init_file = INIT_FILE;

endmodule

// File: tb/tb_mem_data_be.sv
// tb_mem_data_be: scoreboard bench, LAT=1 and LAT=3 instances.
// Byte-array reference model; expectations queued at accept.
module tb_mem_data_be;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic [1:0]  sz  = 2'd0;
  logic        uns = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] wd  = '0;

  logic        v1 = 1'b0, rr1 = 1'b1, rdy1, rv1, re1;
  logic [31:0] rd1;
  logic        v3 = 1'b0, rr3 = 1'b1, rdy3, rv3, re3;
  logic [31:0] rd3;

  always #5 clk = ~clk;

  mem_data_be #(.WORD(32), .ADDR(16), .DEPTH(1024), .LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .req_valid(v1), .req_ready(rdy1), .req_we(we), .req_size(sz),
    .req_unsigned(uns), .req_addr(addr), .req_wdata(wd),
    .resp_valid(rv1), .resp_ready(rr1), .resp_rdata(rd1), .resp_err(re1)
  );

  mem_data_be #(.WORD(32), .ADDR(16), .DEPTH(1024), .LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .req_valid(v3), .req_ready(rdy3), .req_we(we), .req_size(sz),
    .req_unsigned(uns), .req_addr(addr), .req_wdata(wd),
    .resp_valid(rv3), .resp_ready(rr3), .resp_rdata(rd3), .resp_err(re3)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  logic [7:0] mdl [2][4096];
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int k, input logic w,
                                 input logic [1:0] s, input logic u,
                                 input logic [15:0] a, input logic [31:0] d);
    exp_t e;
    int n;
    int kk;
    logic bad;
    logic [31:0] v;
    kk = (k == 1) ? 0 : 1;
    n = 1 << s;
    bad = (s == 2'd3) || ((int'(a) % n) != 0) || (a >= 16'h1000);
    e.rdata = '0;
    e.err = bad;
    e.cyc = 0;
    if (!bad) begin
      if (w) begin
        for (int i = 0; i < n; i++) mdl[kk][int'(a) + i] = d[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[kk][int'(a) + i];
        if (!u && n < 4 && v[8*n-1])
          for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        e.rdata = v;
      end
    end
    return e;
  endfunction

  task automatic issue(input int k, input logic w, input logic [1:0] s,
                       input logic u, input logic [15:0] a,
                       input logic [31:0] d);
    exp_t e;
    int n;
    logic r;
    we = w; sz = s; uns = u; addr = a; wd = d;
    if (k == 1) v1 = 1'b1; else v3 = 1'b1;
    n = 0;
    r = 1'b0;
    forever begin
      @(negedge clk);
      r = (k == 1) ? rdy1 : rdy3;
      if (r) break;
      n++;
      if (n > 40) begin
        chk("req_timeout", 64'(r), 64'd1);
        break;
      end
    end
    if (r) begin
      e = model(k, w, s, u, a, d);
      e.cyc = cyc;
      if (k == 1) q1.push_back(e);
      else q3.push_back(e);
    end
    @(posedge clk);
    #1;
    v1 = 1'b0;
    v3 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || q3.size() != 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_q1", 64'(q1.size()), 64'd0);
    chk("drain_q3", 64'(q3.size()), 64'd0);
  endtask

  // u1 scoreboard: data, error and exact one-cycle latency
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rv1 && rr1) begin
      if (q1.size() == 0) chk("u1_spurious", 64'(rv1), 64'd0);
      else begin
        e = q1.pop_front();
        chk("u1_rdata", 64'(rd1), 64'(e.rdata));
        chk("u1_err", 64'(re1), 64'(e.err));
        chk("u1_lat", 64'(cyc - e.cyc), 64'd1);
      end
    end
  end

  // u3 scoreboard: data, error and issue order
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rv3 && rr3) begin
      if (q3.size() == 0) chk("u3_spurious", 64'(rv3), 64'd0);
      else begin
        e = q3.pop_front();
        chk("u3_rdata", 64'(rd3), 64'(e.rdata));
        chk("u3_err", 64'(re3), 64'(e.err));
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(rv1), 64'd0);
    chk("rst_rdata", 64'(rd1), 64'd0);
    chk("rst_err", 64'(re1), 64'd0);
    chk("rst_ready", 64'(rdy1), 64'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 64; i++)
      issue(1, 1'b1, 2'd2, 1'b0, 16'(4 * i), $urandom);
    issue(1, 1'b1, 2'd2, 1'b0, 16'h10, 32'hDEADBEEF);
    issue(1, 1'b0, 2'd2, 1'b0, 16'h10, 32'h0);
    issue(1, 1'b0, 2'd0, 1'b0, 16'h13, 32'h0);
    issue(1, 1'b0, 2'd0, 1'b1, 16'h13, 32'h0);
    issue(1, 1'b0, 2'd1, 1'b0, 16'h12, 32'h0);
    issue(1, 1'b0, 2'd1, 1'b1, 16'h12, 32'h0);
    issue(1, 1'b1, 2'd0, 1'b0, 16'h11, 32'hFFFFFF55);
    issue(1, 1'b0, 2'd2, 1'b0, 16'h10, 32'h0);
    issue(1, 1'b0, 2'd1, 1'b0, 16'h11, 32'h0);
    issue(1, 1'b1, 2'd2, 1'b0, 16'h0, 32'h01234567);
    issue(1, 1'b1, 2'd2, 1'b0, 16'h1000, 32'hFFFFFFFF);
    issue(1, 1'b0, 2'd2, 1'b0, 16'h0, 32'h0);
    issue(1, 1'b0, 2'd3, 1'b0, 16'h18, 32'h0);
    issue(1, 1'b1, 2'd2, 1'b0, 16'h1A, 32'h0);
    for (int i = 0; i < 24; i++) begin
      logic [1:0] s;
      s = 2'($urandom_range(0, 2));
      issue(1, 1'($urandom), s, 1'($urandom),
            16'($urandom_range(0, 255)) & ~16'((1 << s) - 1), $urandom);
    end
    drain();

    for (int i = 0; i < 5; i++)
      issue(3, 1'b1, 2'd2, 1'b0, 16'(32 + 4 * i), 32'hA0000000 + 32'(i));
    drain();
    rr3 = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          issue(3, 1'b0, 2'd2, 1'b0, 16'(32 + 4 * i), 32'h0);
      end
      begin
        repeat (5) @(negedge clk);
        chk("bp_ready_low", 64'(rdy3), 64'd0);
        chk("bp_valid_hold", 64'(rv3), 64'd1);
        chk("bp_rdata_hold", 64'(rd3), 64'hA0000000);
        @(posedge clk);
        #1 rr3 = 1'b1;
      end
    join
    drain();

    issue(3, 1'b1, 2'd2, 1'b0, 16'h40, 32'hCAFEF00D);
    drain();
    issue(3, 1'b0, 2'd2, 1'b0, 16'h40, 32'h0);
    issue(3, 1'b0, 2'd2, 1'b0, 16'h40, 32'h0);
    rst = 1'b1;
    q3.delete();
    we = 1'b1; sz = 2'd2; addr = 16'h40; wd = 32'h11111111; v3 = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    v3 = 1'b0;
    @(negedge clk);
    chk("mrst_valid", 64'(rv3), 64'd0);
    chk("mrst_rdata", 64'(rd3), 64'd0);
    chk("mrst_err", 64'(re3), 64'd0);
    chk("mrst_ready", 64'(rdy3), 64'd1);
    @(posedge clk);
    #1;
    issue(3, 1'b0, 2'd2, 1'b0, 16'h40, 32'h0);
    issue(3, 1'b0, 2'd0, 1'b1, 16'h43, 32'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
